// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and sync-decoder FSM states
package vga_timing_pkg;
    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_SYNC_ALIGN = 657;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_SYNC_ALIGN = 490;
    localparam int VGA_LOCK_FRAMES  = 2;
    localparam logic [9:0] CNT_MAX  = 10'd1023;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
endpackage

// File: rtl/sync_fall_detect.sv
// sync_fall_detect: flags the cycle in which an active-low sync input falls
module sync_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic fall
);
    logic prev;

    // Previous-value register idles high so a sync held low out of reset reads as a fall
    always_ff @(posedge clk or posedge rst)
        if (rst) prev <= 1'b1;
        else prev <= sync_in;

    assign fall = prev & ~sync_in;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and timing lock from VGA sync inputs.
// Define VGA_SYNC_DECODER_STATS_EN to build the saturating lock-loss counter.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_SYNC_ALIGN = VGA_H_SYNC_ALIGN,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_SYNC_ALIGN = VGA_V_SYNC_ALIGN,
    parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       locked,
    output logic [9:0] h_meas,
    output logic [9:0] v_meas,
    output logic       err,
    output logic [7:0] err_count
);
    logic h_fall, v_fall, x_wrap, armed, line_bad_seen, bad_line, frame_good, lock_loss;
    logic [9:0] h_cnt, l_cnt, h_next, l_next;
    logic [7:0] good_cnt;
    state_t state;

    sync_fall_detect u_hfall (.clk(clk25), .rst(rst), .sync_in(hsync_in), .fall(h_fall));
    sync_fall_detect u_vfall (.clk(clk25), .rst(rst), .sync_in(vsync_in), .fall(v_fall));

    assign x_wrap     = !h_fall && x == 10'(H_TOTAL - 1);
    assign h_next     = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
    // A coincident hsync fall is counted into the line total seen by a vsync fall
    assign l_next     = (h_fall && l_cnt != CNT_MAX) ? l_cnt + 10'd1 : l_cnt;
    assign bad_line   = (h_fall && armed && h_next != 10'(H_TOTAL)) || h_cnt == CNT_MAX;
    assign frame_good = l_next == 10'(V_TOTAL) && !line_bad_seen && !bad_line;
    assign lock_loss  = bad_line || (v_fall && !frame_good);
    assign video_on   = locked && x < 10'(H_ACTIVE) && y < 10'(V_ACTIVE);

    // Free-running position, snapped to the sync alignment values on each fall
    always_ff @(posedge clk25 or posedge rst)
        if (rst) begin
            x <= 10'd0;
            y <= 10'd0;
        end else begin
            x <= h_fall ? 10'(H_SYNC_ALIGN) : x_wrap ? 10'd0 : x + 10'd1;
            y <= v_fall ? 10'(V_SYNC_ALIGN) : !x_wrap ? y : (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
        end

    // Line period and frame length measurement; first hsync fall only arms checking
    always_ff @(posedge clk25 or posedge rst)
        if (rst) begin
            h_cnt         <= 10'd0;
            l_cnt         <= 10'd0;
            h_meas        <= 10'd0;
            v_meas        <= 10'd0;
            armed         <= 1'b0;
            line_bad_seen <= 1'b0;
        end else begin
            h_cnt         <= h_fall ? 10'd0 : h_next;
            l_cnt         <= v_fall ? 10'd0 : l_next;
            line_bad_seen <= v_fall ? 1'b0 : line_bad_seen | bad_line;
            if (h_fall) begin
                h_meas <= h_next;
                armed  <= 1'b1;
            end
            if (v_fall) v_meas <= l_next;
        end

    // Lock FSM with registered locked flag and lock-loss pulse
    always_ff @(posedge clk25 or posedge rst)
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= 8'd0;
            locked   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                SEARCH: if (v_fall) begin
                    state    <= CHECK;
                    good_cnt <= 8'd0;
                end
                CHECK: if (lock_loss) state <= SEARCH;
                    else if (v_fall) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == 8'(LOCK_FRAMES)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                LOCKED: if (lock_loss) begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                    err    <= 1'b1;
                end
                default: state <= SEARCH;
            endcase
        end

`ifdef VGA_SYNC_DECODER_STATS_EN
    // Saturating count of lock-loss pulses
    always_ff @(posedge clk25 or posedge rst)
        if (rst) err_count <= 8'd0;
        else if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
`else
    assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of sync decoding, lock, error and reset behaviour
module tb_vga_sync_decoder;
    localparam int HT  = 800;
    localparam int HA  = 640;
    localparam int HSA = 657;
    localparam int VT  = 4;
    localparam int VA  = 2;
    localparam int VSA = 3;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] x, y, h_meas, v_meas;
    logic       video_on, locked, err;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_bad = 0;
    int cur_l = -1;
    int cur_c = -1;
    int rise_l = -1;
    int rise_c = -1;
    int err_hi = 0;
    logic [9:0] h_first = 10'd0;
    bit was_locked = 1'b0;
    bit pos_chk = 1'b0;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_ALIGN(HSA),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_ALIGN(VSA), .LOCK_FRAMES(2)
    ) dut (
        .clk25(clk25), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .x(x), .y(y), .video_on(video_on), .locked(locked),
        .h_meas(h_meas), .v_meas(v_meas), .err(err), .err_count(err_count)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        int xe, ye;
        @(posedge clk25);
        #1;
        if (err) err_hi++;
        if (locked && !was_locked && rise_l < 0) begin
            rise_l = cur_l;
            rise_c = cur_c;
        end
        was_locked = locked;
        if (cur_l == 0 && cur_c == 0) h_first = h_meas;
        if (pos_chk) begin
            xe = (HSA + cur_c) % HT;
            ye = (cur_c >= HT - HSA) ? cur_l : (cur_l + VT - 1) % VT;
            chk("pos_x", 32'(x), 32'(xe));
            chk("pos_y", 32'(y), 32'(ye));
            chk("video_on", 32'(video_on), 32'(xe < HA && ye < VA));
        end
    endtask

    task automatic frame(input int bad_at, input int bad_len, input int n_lines);
        int len;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == bad_at) ? bad_len : HT;
            for (int c = 0; c < len; c++) begin
                cur_l = l;
                cur_c = c;
                hsync_in = (c >= 96);
                vsync_in = (l >= 2);
                tick();
            end
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_h_meas", 32'(h_meas), 0);
        chk("rst_v_meas", 32'(v_meas), 0);
        chk("rst_err_count", 32'(err_count), 0);
        @(negedge clk25);
        rst = 1'b0;
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        chk("pre_lock", 32'(locked), 0);
        frame(-1, 0, VT);
        chk("lock_line", 32'(rise_l), 0);
        chk("lock_col", 32'(rise_c), 0);
        chk("h_meas_nom", 32'(h_meas), HT);
        chk("v_meas_nom", 32'(v_meas), VT);
        chk("no_err_nom", 32'(err_hi), 0);
        pos_chk = 1'b1;
        frame(-1, 0, VT);
        pos_chk = 1'b0;
        chk("still_locked", 32'(locked), 1);
        err_hi = 0;
        frame(2, HT - 1, VT);
        chk("short_err_pulses", 32'(err_hi), 1);
        chk("short_locked", 32'(locked), 0);
        rise_l = -1;
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        chk("relock_early", 32'(locked), 0);
        frame(-1, 0, VT);
        chk("relock_line", 32'(rise_l), 0);
        chk("relock_col", 32'(rise_c), 0);
        chk("relock_err", 32'(err_hi), 1);
        err_hi = 0;
        cur_l = -1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (2000) tick();
        chk("hold_err_pulses", 32'(err_hi), 1);
        chk("hold_locked", 32'(locked), 0);
        frame(-1, 0, VT);
        chk("hold_h_meas_sat", 32'(h_first), 1023);
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        chk("relock2", 32'(locked), 1);
        err_hi = 0;
        frame(1, HT - 1, VT);
        chk("loss3_err_pulses", 32'(err_hi), 1);
        chk("loss3_locked", 32'(locked), 0);
`ifdef VGA_SYNC_DECODER_STATS_EN
        chk("err_count", 32'(err_count), 3);
`else
        chk("err_count", 32'(err_count), 0);
`endif
        frame(-1, 0, VT);
        frame(-1, 0, VT);
        frame(-1, 0, 2);
        chk("pre_rst_locked", 32'(locked), 1);
        err_hi = 0;
        @(negedge clk25);
        rst = 1'b1;
        #1;
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_x", 32'(x), 0);
        chk("midrst_y", 32'(y), 0);
        chk("midrst_err", 32'(err), 0);
        repeat (3) tick();
        chk("midrst_no_err", 32'(err_hi), 0);
        chk("midrst_err_count", 32'(err_count), 0);
        @(negedge clk25);
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- H_TOTAL, 800, clocks per line
- H_ACTIVE, 640, visible pixels
- H_SYNC_ALIGN, 657, x value loaded on hsync fall
- V_TOTAL, 525, lines per frame
- V_ACTIVE, 480, visible lines
- V_SYNC_ALIGN, 490, y value loaded on vsync fall
- LOCK_FRAMES, 2, consecutive good frames required for lock
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk25, in, 1, 25 MHz pixel clock
- rst, in, 1, async active-high reset
- hsync_in, in, 1, active-low horizontal sync
- vsync_in, in, 1, active-low vertical sync
- x, out, 10, recovered pixel column
- y, out, 10, recovered line
- video_on, out, 1, recovered active-area flag
- locked, out, 1, timing lock
- h_meas, out, 10, last measured line period
- v_meas, out, 10, last measured frame length in lines
- err, out, 1, one-cycle lock-loss pulse
- err_count, out, 8, lock-loss counter

Function
REQ-010 Fall detection: a fall SHALL be detected in a cycle where the input is 0 and its registered previous value is 1; the previous-value register SHALL reset to 1.
REQ-011 x SHALL load H_SYNC_ALIGN on the edge at which an hsync fall is detected. Otherwise x SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-012 y SHALL load V_SYNC_ALIGN on a vsync fall. Otherwise y SHALL increment on each x wrap, wrapping from V_TOTAL-1 to 0. A vsync fall SHALL take priority over a simultaneous x wrap.
REQ-013 An h period counter SHALL count clocks since the last hsync fall and saturate at 1023. On each hsync fall, h_meas SHALL load the count plus 1 (saturated at 1023), and the counter SHALL restart at 0.
REQ-014 A line counter SHALL count hsync falls since the last vsync fall, saturating at 1023. On each vsync fall, v_meas SHALL load the count and the counter SHALL clear.
REQ-015 A line SHALL be bad if its hsync fall yields h_meas != H_TOTAL, or if the h period counter reaches 1023. The first hsync fall after reset SHALL be unchecked.
REQ-016 A frame SHALL be good if its vsync fall yields v_meas == V_TOTAL and no bad line occurred since the previous vsync fall.
REQ-017 FSM states SHALL be SEARCH, CHECK and LOCKED:
- SEARCH -> CHECK on any vsync fall, with good-frame count = 0.
- CHECK: on a good frame, increment the count; on reaching LOCK_FRAMES, go to LOCKED.
- CHECK -> SEARCH on a bad line or a bad frame.
- LOCKED -> SEARCH on a bad line or a bad frame.
REQ-018 locked SHALL be registered and high exactly in state LOCKED.
REQ-019 err SHALL pulse high for one cycle on the edge after a LOCKED -> SEARCH transition.
REQ-020 video_on SHALL be combinational: locked && x < H_ACTIVE && y < V_ACTIVE.
REQ-021 Simultaneous hsync and vsync falls SHALL be handled in the same cycle. The line counter SHALL include that hsync fall before loading v_meas.

Reset
REQ-030 Reset SHALL drive the following to these values:
- x, y, h_meas, v_meas, err_count: 0
- locked, err: 0
- state: SEARCH
- both counters: 0
REQ-031 Reset asserted mid-frame SHALL drop locked immediately without pulsing err.

Configuration
REQ-040 With VGA_SYNC_DECODER_STATS_EN defined, err_count SHALL increment on each err pulse, saturating at 255.
REQ-041 Without VGA_SYNC_DECODER_STATS_EN, err_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
REQ-050 A shared package vga_timing_pkg SHALL hold the 640x480@60 timing constants and the FSM state enum, shared with the timing generator.
REQ-051 Fall detection SHALL be one sub-module, sync_fall_detect, instantiated once per sync input.

Verification
REQ-060 Directed scenarios:
- Nominal 800x525 timing (hsync low 96 clocks, vsync low 2 lines): locked rises one edge after the 3rd vsync fall; h_meas = 800; v_meas = 525.
- Locked, then one line of 799 clocks: err pulses for 1 cycle, locked = 0, FSM returns to SEARCH; it relocks after 2 further good frames.
- hsync held high for 2000 clocks while locked: h_meas saturates at 1023, err pulses, locked = 0.
- While locked, check recovered position: x = 657 the edge after each hsync fall; video_on high exactly for x in 0..639 and y in 0..479.
- rst pulsed mid-frame while locked: locked = 0 and x = y = 0 immediately, with no err pulse.
- STATS build: 3 induced lock losses give err_count = 3; non-STATS build: err_count stays 0.
